prog_loader: RTL and testbench

- Hardware program loader that writes instruction words into the processor's instruction/data memory from a byte stream, replacing the simulation-only hex-file preload.
- Sits between a host byte source (UART receiver or debug port) and the memory write port of pipeline_RISCV.
- Holds the core halted while loading, verifies a checksum, then releases the core with a one-cycle PC-clear pulse.

---
 rtl/prog_loader_if.sv | 30 +++
 rtl/prog_loader.sv | 138 +++++++++++++
 tb/tb_prog_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Byte-stream, memory-write and core-control bundle for the program loader.
// master is the host/memory/core side; slave is the loader itself.
interface prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_halt;
    logic              cpu_start;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_halt, cpu_start, busy, done, err
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata,
        output cpu_halt, cpu_start, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a length-prefixed, XOR-checksummed word stream into instruction memory,
// holding the core halted until the image is verified, then pulses cpu_start.
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic         clk1,
    input  logic         rst,
    prog_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, RUN, ERROR} state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       CAPACITY = 32'd1 << ADDR_W;

    state_t            state_reg;
    logic [7:0]        len_hi_reg;
    logic [15:0]       len_reg;
    logic [15:0]       word_cnt_reg;
    logic [1:0]        byte_idx_reg;
    logic [23:0]       shift_reg;
    logic [7:0]        csum_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              cpu_halt_reg;
    logic              cpu_start_reg;
    logic              done_reg;
    logic              err_reg;

    logic        ready;
    logic        xfer;
    logic [15:0] n_full;
    logic        last_word;

    assign ready     = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                       (state_reg == DATA)   || (state_reg == CSUM);
    assign xfer      = bus.byte_valid && ready;
    assign n_full    = {len_hi_reg, bus.byte_in};
    assign last_word = (word_cnt_reg == len_reg - 16'd1);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            len_hi_reg    <= '0;
            len_reg       <= '0;
            word_cnt_reg  <= '0;
            byte_idx_reg  <= '0;
            shift_reg     <= '0;
            csum_reg      <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= BASE;
            mem_wdata_reg <= '0;
            cpu_halt_reg  <= 1'b1;
            cpu_start_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            mem_we_reg    <= 1'b0;
            cpu_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg    <= LEN_HI;
                        done_reg     <= 1'b0;
                        err_reg      <= 1'b0;
                        csum_reg     <= '0;
                        cpu_halt_reg <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi_reg <= bus.byte_in;
                        state_reg  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_reg      <= n_full;
                        word_cnt_reg <= '0;
                        byte_idx_reg <= '0;
                        if (32'(n_full) > CAPACITY) begin
                            state_reg <= ERROR;
                            err_reg   <= 1'b1;
                        end else if (n_full == 16'd0) begin
                            state_reg <= CSUM;
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum_reg     <= csum_reg ^ bus.byte_in;
                        shift_reg    <= {shift_reg[15:0], bus.byte_in};
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            mem_we_reg    <= 1'b1;
                            mem_wdata_reg <= {shift_reg, bus.byte_in};
                            mem_addr_reg  <= BASE + ADDR_W'(word_cnt_reg);
                            word_cnt_reg  <= word_cnt_reg + 16'd1;
                            if (last_word) begin
                                state_reg <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        if (bus.byte_in == csum_reg) begin
                            state_reg     <= RUN;
                            cpu_start_reg <= 1'b1;
                            cpu_halt_reg  <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            state_reg <= ERROR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                RUN:     state_reg <= IDLE;
                ERROR:   state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready = ready;
    assign bus.busy       = ready;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.cpu_halt   = cpu_halt_reg;
    assign bus.cpu_start  = cpu_start_reg;
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and random frames compared
// against a frame-level model (expected words, XOR checksum, outcome).
module tb_prog_loader;
    localparam int AW  = 4;
    localparam int CAP = 1 << AW;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    prog_loader_if #(.ADDR_W(AW)) bus ();

    prog_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int  checks    = 0;
    int  errors    = 0;
    int  cyc       = 0;
    int  start_cnt = 0;
    wr_t wr_q[$];

    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (bus.mem_we === 1'b1) wr_q.push_back('{cyc, 32'(bus.mem_addr), bus.mem_wdata});
        if (bus.cpu_start === 1'b1) start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_we"},    32'(bus.mem_we),     0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr),   0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,       0);
        check({tag, "_cpu_halt"},  32'(bus.cpu_halt),   1);
        check({tag, "_cpu_start"}, 32'(bus.cpu_start),  0);
        check({tag, "_done"},      32'(bus.done),       0);
        check({tag, "_err"},       32'(bus.err),        0);
        check({tag, "_busy"},      32'(bus.busy),       0);
        check({tag, "_ready"},     32'(bus.byte_ready), 0);
    endtask

    // Entered and left just after a falling edge; ec is the transfer edge number.
    task automatic send_byte(input logic [7:0] b, input int gap, output int ec);
        int t;
        t = 0;
        repeat (gap) begin
            bus.byte_valid = 1'b0;
            bus.byte_in    = 8'($urandom);
            @(negedge clk1);
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && t < 40) begin
            @(negedge clk1);
            t++;
        end
        if (t >= 40) check("ready_timeout", 32'(bus.byte_ready), 1);
        @(negedge clk1);
        ec = cyc;
        bus.byte_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 1) return 1;
        if (mode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    // cs_sel: -1 = correct checksum, -2 = corrupted checksum, else the literal byte.
    task automatic run_frame(input string tag, input int n, input logic [31:0] words[$],
                             input int cs_sel, input int mode);
        logic [7:0] cs;
        logic [7:0] sent;
        logic       ok;
        int         ec;
        int         edges[$];
        int         wbase;
        int         sbase;
        cs = 8'h00;
        for (int i = 0; i < words.size(); i++)
            for (int k = 0; k < 4; k++) cs ^= words[i][31-8*k -: 8];
        if (cs_sel == -1)      sent = cs;
        else if (cs_sel == -2) sent = cs ^ (8'h01 << $urandom_range(0, 7));
        else                   sent = 8'(cs_sel);
        ok    = (n <= CAP) && (sent == cs);
        wbase = wr_q.size();
        sbase = start_cnt;

        bus.start = 1'b1;
        @(negedge clk1);
        bus.start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(bus.busy), 1);
        check({tag, "_halt_loading"},     32'(bus.cpu_halt), 1);
        check({tag, "_done_cleared"},     32'(bus.done), 0);
        check({tag, "_err_cleared"},      32'(bus.err), 0);

        send_byte(8'(n >> 8), pick_gap(mode), ec);
        send_byte(8'(n), pick_gap(mode), ec);

        if (n > CAP) begin
            check({tag, "_oversize_err"},   32'(bus.err), 1);
            check({tag, "_oversize_ready"}, 32'(bus.byte_ready), 0);
            check({tag, "_oversize_halt"},  32'(bus.cpu_halt), 1);
            repeat (3) @(negedge clk1);
            check({tag, "_oversize_idle"},   32'(bus.busy), 0);
            check({tag, "_oversize_sticky"}, 32'(bus.err), 1);
            check({tag, "_oversize_writes"}, 32'(wr_q.size() - wbase), 0);
            check({tag, "_oversize_starts"}, 32'(start_cnt - sbase), 0);
            $display("frame %s: n=%0d oversize err=%0b writes=%0d", tag, n, bus.err,
                     wr_q.size() - wbase);
            return;
        end

        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) begin
                send_byte(words[i][31-8*k -: 8], pick_gap(mode), ec);
                if (k == 3) edges.push_back(ec);
            end
        send_byte(sent, pick_gap(mode), ec);

        check({tag, "_cpu_start"}, 32'(bus.cpu_start), 32'(ok));
        check({tag, "_cpu_halt"},  32'(bus.cpu_halt), 32'(!ok));
        check({tag, "_done"},      32'(bus.done), 32'(ok));
        check({tag, "_err"},       32'(bus.err), 32'(!ok));
        check({tag, "_ready_end"}, 32'(bus.byte_ready), 0);
        repeat (2) @(negedge clk1);
        check({tag, "_idle"},       32'(bus.busy), 0);
        check({tag, "_start_low"},  32'(bus.cpu_start), 0);
        check({tag, "_done_hold"},  32'(bus.done), 32'(ok));
        check({tag, "_writes"},     32'(wr_q.size() - wbase), 32'(n));
        for (int i = 0; i < n && wbase + i < wr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_q[wbase+i].addr, 32'(i % CAP));
            check($sformatf("%s_data%0d", tag, i), wr_q[wbase+i].data, words[i]);
            check($sformatf("%s_lat%0d", tag, i),  32'(wr_q[wbase+i].cyc), 32'(edges[i]));
        end
        check({tag, "_start_pulses"}, 32'(start_cnt - sbase), 32'(ok));
        $display("frame %s: n=%0d csum=%h sent=%h done=%0b err=%0b writes=%0d", tag, n, cs,
                 sent, bus.done, bus.err, wr_q.size() - wbase);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog[$];
        logic [31:0] rnd[$];
        logic [31:0] none[$];
        int          ec;
        int          wbase;
        int          n;
        int          sel;

        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk1);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk1);
        check("idle_after_reset_busy", 32'(bus.busy), 0);

        // XOR of these 16 data bytes is 0xE3.
        prog = '{32'h2801000a, 32'h28020014, 32'h00222000, 32'hfc000000};
        run_frame("four_word", 4, prog, -1, 0);
        run_frame("bad_csum", 4, prog, 8'h00, 0);
        run_frame("zero_len", 0, none, -1, 0);
        run_frame("oversize17", CAP + 1, none, -1, 0);
        run_frame("oversize256", 256, none, -1, 0);

        rnd.delete();
        for (int i = 0; i < CAP; i++) rnd.push_back($urandom);
        run_frame("full_cap", CAP, rnd, -1, 0);

        run_frame("gapped", 4, prog, -1, 1);

        // Abort between the 2nd and 3rd bytes of word 1.
        wbase = wr_q.size();
        bus.start = 1'b1;
        @(negedge clk1);
        bus.start = 1'b0;
        send_byte(8'h00, 0, ec);
        send_byte(8'h04, 0, ec);
        for (int k = 0; k < 6; k++) send_byte(8'(prog[k/4] >> (24 - 8*(k%4))), 0, ec);
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h5a;
        repeat (3) @(negedge clk1);
        rst = 1'b0;
        repeat (3) @(negedge clk1);
        bus.byte_valid = 1'b0;
        check("async_rst_writes", 32'(wr_q.size() - wbase), 1);
        check("async_rst_halt", 32'(bus.cpu_halt), 1);
        $display("abort: reset mid-word writes=%0d halt=%0b", wr_q.size() - wbase, bus.cpu_halt);
        run_frame("after_rst", 4, prog, -1, 0);

        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(0, CAP + 2));
            rnd.delete();
            for (int i = 0; i < n && i < CAP; i++) rnd.push_back($urandom);
            sel = ($urandom_range(0, 3) == 0) ? -2 : -1;
            run_frame($sformatf("rand%0d", r), n, rnd, sel, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
